// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run-control FSM plus prescaler-gated 4-digit BCD up/down counter.
// Button levels are synchronised and edge-detected; clear outranks start_stop.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        dir,
    input  logic [15:0] preset,
    output logic [15:0] nums,
    output logic        running,
    output logic        done,
    output logic        tick
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [2:0]    ss_sync_r, clr_sync_r;
    logic          ss_edge_s, clr_edge_s;
    logic [PW-1:0] presc_r, presc_nxt_s;
    logic [15:0]   nums_r, nums_nxt_s, step_s;
    logic          dir_r, dir_nxt_s;
    logic          tick_r, tick_nxt_s;
    logic          running_r, done_r;
    logic          wrap_s, step_end_s;

    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] > 4'd9) begin
                r[i*4 +: 4] = 4'd9;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c && (r[i*4 +: 4] == 4'd9)) begin
                r[i*4 +: 4] = 4'd0;
            end else if (c) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                c = 1'b0;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b && (r[i*4 +: 4] == 4'd0)) begin
                r[i*4 +: 4] = 4'd9;
            end else if (b) begin
                r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                b = 1'b0;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    assign ss_edge_s  = ss_sync_r[1] & ~ss_sync_r[2];
    assign clr_edge_s = clr_sync_r[1] & ~clr_sync_r[2];
    assign wrap_s     = (presc_r == PMAX);
    assign step_s     = dir_r ? bcd_dec(nums_r) : bcd_inc(nums_r);
    assign step_end_s = dir_r ? (step_s == 16'h0000) : (step_s == 16'h9999);

    // Two-flop synchronisers followed by the edge-history flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_sync_r  <= 3'b000;
            clr_sync_r <= 3'b000;
        end else begin
            ss_sync_r  <= {ss_sync_r[1:0], start_stop};
            clr_sync_r <= {clr_sync_r[1:0], clear};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a start from IDLE with nothing left to count goes straight to DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_edge_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (ss_edge_s) begin
                    state_nxt_s = (dir_r && (nums_r == 16'h0000)) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (clr_edge_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (ss_edge_s) begin
                    state_nxt_s = ST_PAUSE;
                end else if (wrap_s && step_end_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (clr_edge_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (ss_edge_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (clr_edge_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath next values: the prescaler only advances in RUN when no button edge is pending.
    always_comb begin
        presc_nxt_s = presc_r;
        nums_nxt_s  = nums_r;
        dir_nxt_s   = dir_r;
        tick_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                nums_nxt_s  = dir ? clamp_bcd(preset) : 16'h0000;
                dir_nxt_s   = dir;
                presc_nxt_s = '0;
            end
            ST_RUN: begin
                if (clr_edge_s) begin
                    presc_nxt_s = '0;
                end else if (ss_edge_s) begin
                    presc_nxt_s = presc_r;
                end else if (wrap_s) begin
                    presc_nxt_s = '0;
                    tick_nxt_s  = 1'b1;
                    nums_nxt_s  = step_s;
                end else begin
                    presc_nxt_s = presc_r + PW'(1);
                end
            end
            ST_PAUSE, ST_DONE: begin
                if (clr_edge_s) begin
                    presc_nxt_s = '0;
                end else begin
                    presc_nxt_s = presc_r;
                end
            end
            default: presc_nxt_s = '0;
        endcase
    end

    // Datapath and status registers; status flags decode the current state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r   <= '0;
            nums_r    <= 16'h0000;
            dir_r     <= 1'b0;
            tick_r    <= 1'b0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            presc_r   <= presc_nxt_s;
            nums_r    <= nums_nxt_s;
            dir_r     <= dir_nxt_s;
            tick_r    <= tick_nxt_s;
            running_r <= (state_r == ST_RUN);
            done_r    <= (state_r == ST_DONE);
        end
    end

    assign nums    = nums_r;
    assign running = running_r;
    assign done    = done_r;
    assign tick    = tick_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: integer-valued behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_stopwatch_ctrl;
    localparam int TD = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk;
    logic        rst;
    logic        start_stop;
    logic        clear;
    logic        dir;
    logic [15:0] preset;
    logic [15:0] nums;
    logic        running;
    logic        done;
    logic        tick;

    int n_checks;
    int n_fail;

    stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .dir        (dir),
        .preset     (preset),
        .nums       (nums),
        .running    (running),
        .done       (done),
        .tick       (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic int clamp_val(input logic [15:0] p);
        int v;
        int d;
        int w;
        v = 0;
        w = 1;
        for (int i = 0; i < 4; i++) begin
            d = int'((p >> (4 * i)) & 16'h000F);
            if (d > 9) d = 9;
            v = v + d * w;
            w = w * 10;
        end
        return v;
    endfunction

    // Behavioural model: integer count value, mode, and input histories; compared each cycle.
    initial begin : model
        int  ss_h[3];
        int  cl_h[3];
        int  mode;
        int  val;
        int  presc;
        int  dn;
        int  e_run;
        int  e_done;
        int  e_tick;
        bit  sse;
        bit  cle;
        for (int i = 0; i < 3; i++) begin
            ss_h[i] = 0;
            cl_h[i] = 0;
        end
        mode = M_IDLE; val = 0; presc = 0; dn = 0;
        e_run = 0; e_done = 0; e_tick = 0;
        forever begin
            @(posedge clk);
            if (rst !== 1'b1) begin
                for (int i = 0; i < 3; i++) begin
                    ss_h[i] = 0;
                    cl_h[i] = 0;
                end
                mode = M_IDLE; val = 0; presc = 0; dn = 0;
                e_run = 0; e_done = 0; e_tick = 0;
            end else begin
                sse    = (ss_h[1] == 1) && (ss_h[2] == 0);
                cle    = (cl_h[1] == 1) && (cl_h[2] == 0);
                e_run  = (mode == M_RUN) ? 1 : 0;
                e_done = (mode == M_DONE) ? 1 : 0;
                e_tick = 0;
                if (cle) begin
                    if (mode == M_IDLE) begin
                        val = dir ? clamp_val(preset) : 0;
                        dn  = dir ? 1 : 0;
                    end
                    mode  = M_IDLE;
                    presc = 0;
                end else begin
                    case (mode)
                        M_IDLE: begin
                            if (sse) mode = (dn == 1 && val == 0) ? M_DONE : M_RUN;
                            val   = dir ? clamp_val(preset) : 0;
                            dn    = dir ? 1 : 0;
                            presc = 0;
                        end
                        M_RUN: begin
                            if (sse) begin
                                mode = M_PAUSE;
                            end else if (presc == TD - 1) begin
                                presc  = 0;
                                e_tick = 1;
                                val    = (dn == 1) ? val - 1 : val + 1;
                                if ((dn == 1 && val == 0) || (dn == 0 && val == 9999)) mode = M_DONE;
                            end else begin
                                presc = presc + 1;
                            end
                        end
                        M_PAUSE: begin
                            if (sse) mode = M_RUN;
                        end
                        default: ;
                    endcase
                end
                ss_h[2] = ss_h[1]; ss_h[1] = ss_h[0]; ss_h[0] = start_stop ? 1 : 0;
                cl_h[2] = cl_h[1]; cl_h[1] = cl_h[0]; cl_h[0] = clear ? 1 : 0;
            end
            #2;
            check("model_nums", nums, to_bcd(val));
            check("model_running", {15'd0, running}, 16'(e_run));
            check("model_done", {15'd0, done}, 16'(e_done));
            check("model_tick", {15'd0, tick}, 16'(e_tick));
        end
    end

    task automatic press_ss();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
    endtask

    task automatic press_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_nums(input logic [15:0] v, input int budget, input string name);
        int n;
        n = 0;
        while (nums !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, nums, v);
    endtask

    task automatic wait_tick(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < budget);
        check("wait_tick", {15'd0, tick}, 16'd1);
    endtask

    task automatic watch_tick(input int cycles, output logic seen);
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            seen = seen | tick;
        end
    endtask

    // Directed scenarios.
    initial begin : stim
        logic seen;
        int   n;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0; start_stop = 1'b0; clear = 1'b0; dir = 1'b0; preset = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_nums", nums, 16'h0000);
        check("rst_running", {15'd0, running}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_tick", {15'd0, tick}, 16'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 1: start latency and first ticks
        press_ss();
        repeat (2) @(negedge clk);
        check("t1_running_early", {15'd0, running}, 16'd0);
        @(negedge clk);
        check("t1_running", {15'd0, running}, 16'd1);
        repeat (2) @(negedge clk);
        check("t1_no_tick", {15'd0, tick}, 16'd0);
        @(negedge clk);
        check("t1_tick1", {15'd0, tick}, 16'd1);
        check("t1_nums1", nums, 16'h0001);
        @(negedge clk);
        check("t1_tick_pulse", {15'd0, tick}, 16'd0);
        repeat (3) @(negedge clk);
        check("t1_tick2", {15'd0, tick}, 16'd1);
        check("t1_nums2", nums, 16'h0002);

        // 2: carries and terminal count
        wait_nums(16'h0009, 60, "t2_reach_0009");
        wait_tick(8);
        check("t2_carry_0010", nums, 16'h0010);
        wait_nums(16'h0099, 400, "t2_reach_0099");
        wait_tick(8);
        check("t2_carry_0100", nums, 16'h0100);
        n = 0;
        while (done !== 1'b1 && n < 42000) begin
            @(negedge clk);
            n++;
        end
        check("t2_done", {15'd0, done}, 16'd1);
        check("t2_nums_9999", nums, 16'h9999);
        press_ss();
        repeat (8) @(negedge clk);
        check("t2_done_hold", {15'd0, done}, 16'd1);
        check("t2_nums_hold", nums, 16'h9999);
        check("t2_not_running", {15'd0, running}, 16'd0);

        // 3: down count from preset, and zero preset
        press_clear();
        dir = 1'b1; preset = 16'h0012;
        repeat (6) @(negedge clk);
        check("t3_preset", nums, 16'h0012);
        press_ss();
        wait_nums(16'h0011, 20, "t3_0011");
        wait_nums(16'h0010, 10, "t3_0010");
        wait_tick(8);
        check("t3_borrow_0009", nums, 16'h0009);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t3_done", {15'd0, done}, 16'd1);
        check("t3_nums_0000", nums, 16'h0000);
        check("t3_not_running", {15'd0, running}, 16'd0);
        press_clear();
        preset = 16'h0000;
        repeat (6) @(negedge clk);
        press_ss();
        watch_tick(6, seen);
        check("t3_zero_done", {15'd0, done}, 16'd1);
        check("t3_zero_no_tick", {15'd0, seen}, 16'd0);

        // 4: pause with prescaler at 2, then resume
        press_clear();
        dir = 1'b0;
        repeat (6) @(negedge clk);
        press_ss();
        wait_tick(12);
        check("t4_first", nums, 16'h0001);
        press_ss();
        watch_tick(22, seen);
        check("t4_hold_nums", nums, 16'h0001);
        check("t4_hold_no_tick", {15'd0, seen}, 16'd0);
        check("t4_paused", {15'd0, running}, 16'd0);
        press_ss();
        repeat (3) @(negedge clk);
        check("t4_resume_early", {15'd0, tick}, 16'd0);
        @(negedge clk);
        check("t4_resume_tick", {15'd0, tick}, 16'd1);
        check("t4_resume_nums", nums, 16'h0002);

        // 5: simultaneous clear and start_stop, then clamped preset
        start_stop = 1'b1; clear = 1'b1;
        @(negedge clk);
        start_stop = 1'b0; clear = 1'b0;
        watch_tick(8, seen);
        check("t5_no_tick", {15'd0, seen}, 16'd0);
        check("t5_nums", nums, 16'h0000);
        check("t5_idle", {15'd0, running}, 16'd0);
        dir = 1'b1; preset = 16'h0A0F;
        repeat (3) @(negedge clk);
        check("t5_clamp", nums, 16'h0909);

        // 6: reset asserted mid-RUN
        dir = 1'b0;
        repeat (3) @(negedge clk);
        press_ss();
        wait_tick(12);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_nums", nums, 16'h0000);
        check("t6_running", {15'd0, running}, 16'd0);
        check("t6_done", {15'd0, done}, 16'd0);
        check("t6_tick", {15'd0, tick}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_nums", nums, 16'h0000);
        check("t6_idle_running", {15'd0, running}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
